mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three ports that meet at the memory arbiter:
//   - instruction port (i_*): read-only requester from the fetch stage
//   - data port (d_*):        read/write requester from the MEM stage
//   - memory port (m_*):      the single unified port toward memory/cache
//
// Handshake: a requester raises i_read / d_read / d_write as a level and holds
// it, with stable address/data/mask, until the matching one-cycle *_resp pulse.
// It may drop the request or present a new one in the cycle after *_resp.
// On the memory side, m_read / m_write and the m_* payload stay constant until
// the memory answers with a one-cycle m_resp; m_rdata is valid with m_resp.
//
// Modports:
//   slave  - the arbiter (consumes requests, drives responses and m_* commands)
//   master - the environment (CPU stages plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [1:0]        d_wmask;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  logic              m_read;
  logic              m_write;
  logic [1:0]        m_wmask;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_resp;

  modport slave (
    input  i_read, i_addr,
    input  d_read, d_write, d_wmask, d_addr, d_wdata,
    input  m_rdata, m_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output m_read, m_write, m_wmask, m_addr, m_wdata
  );

  modport master (
    output i_read, i_addr,
    output d_read, d_write, d_wmask, d_addr, d_wdata,
    output m_rdata, m_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  m_read, m_write, m_wmask, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serializes the instruction-read port and the data read/write port of the
//   pipelined core onto one memory port. Data requests win, except that after
//   STARVE_LIMIT consecutive data grants taken while an instruction read was
//   waiting, the instruction read is granted next.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        mem_port_arbiter_if.slave (i_*, d_*, m_* signal groups)
//   state_dbg  current FSM state (IDLE=0, SERVE_I=1, SERVE_D=2, RESP=3)
//   streak_dbg consecutive-data-grant counter used by the starvation guard
//
// Transaction timing: request sampled at the end of an IDLE cycle, m_* valid
// from the next cycle until m_resp, then one RESP cycle pulsing the granted
// port's *_resp, then back to IDLE (3 cycles per zero-wait transaction).
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mem_port_arbiter_if.slave                 bus,
  output logic [1:0]                        state_dbg,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] streak_dbg
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [SW-1:0]     streak;
  logic              gnt_d;       // granted port of the current transaction
  logic              m_read_q;
  logic              m_write_q;
  logic [1:0]        m_wmask_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic d_req;
  logic take_d;
  logic take_i;
  logic serving;
  logic done;

  // Grant decision is only meaningful in IDLE; RESP never samples requests.
  assign d_req   = bus.d_read | bus.d_write;
  assign take_d  = (state == IDLE) && d_req && (!bus.i_read || (streak < STREAK_MAX));
  assign take_i  = (state == IDLE) && bus.i_read && !take_d;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  assign done    = serving && bus.m_resp;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (take_d) begin
          next_state = SERVE_D;
        end else if (take_i) begin
          next_state = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.m_resp) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.i_resp = 1'b0;
    bus.d_resp = 1'b0;
    if (state == RESP) begin
      bus.i_resp = !gnt_d;
      bus.d_resp = gnt_d;
    end
    state_dbg  = state;
    streak_dbg = streak;
  end

  // Command latches, starvation counter and read-data capture.
  // The strobes are cleared on completion so they are low during RESP; a
  // reset abandons any in-flight command by clearing them asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak    <= '0;
      gnt_d     <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_wmask_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (take_d) begin
      gnt_d     <= 1'b1;
      m_read_q  <= !bus.d_write;  // write wins when both are high
      m_write_q <= bus.d_write;
      m_wmask_q <= bus.d_wmask;
      m_addr_q  <= bus.d_addr;
      m_wdata_q <= bus.d_wdata;
      if (!bus.i_read) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + SW'(1);
      end
    end else if (take_i) begin
      gnt_d     <= 1'b0;
      m_read_q  <= 1'b1;
      m_write_q <= 1'b0;
      m_wmask_q <= '0;
      m_addr_q  <= bus.i_addr;
      m_wdata_q <= '0;
      streak    <= '0;
    end else if (done) begin
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      if (!m_write_q) begin
        if (state == SERVE_D) begin
          d_rdata_q <= bus.m_rdata;
        end else begin
          i_rdata_q <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.m_read  = m_read_q;
  assign bus.m_write = m_write_q;
  assign bus.m_wmask = m_wmask_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios plus a randomized run of mem_port_arbiter against a
//   memory model with configurable wait states and a transaction-level model
//   of the grant order (data first, instruction after LIMIT data grants).
module tb_mem_port_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  mk;
    logic [15:0] a;
    logic [15:0] wd;
  } d_item_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  logic [1:0] state_dbg;
  logic [2:0] streak_dbg;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg),
    .streak_dbg(streak_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  logic [15:0] mem[16];
  int          k_fixed   = 0;     // wait states; negative = random 0..3
  bit          resp_en   = 1'b1;  // 0: m_resp driven manually
  logic        rsp_resp  = 1'b0;
  logic        man_resp  = 1'b0;
  logic [15:0] rsp_rdata = 16'h0;
  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];
  logic [15:0] exp_i_q[$];
  logic [15:0] exp_d_q[$];
  logic [15:0] last_i;
  logic [15:0] last_d;

  assign bus.m_resp  = resp_en ? rsp_resp : man_resp;
  assign bus.m_rdata = rsp_rdata;

  function automatic logic [34:0] pack_cmd(logic wr, logic [1:0] mk, logic [15:0] a, logic [15:0] wd);
    return wr ? {1'b1, mk, a, wd} : {1'b0, 2'b00, a, 16'h0};
  endfunction

  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] wd, logic [1:0] mk);
    return {mk[1] ? wd[15:8] : old[15:8], mk[0] ? wd[7:0] : old[7:0]};
  endfunction

  initial begin : responder
    int cnt;
    bit busy;
    cnt  = 0;
    busy = 1'b0;
    for (int j = 0; j < 16; j++) mem[j] = 16'(j * 16'h0F1D + 16'h2468);
    mem[0] = 16'h1234;
    forever begin
      @(posedge clk);
      #1;
      rsp_resp = 1'b0;
      if (!rst_n) begin
        busy = 1'b0;
      end else if (bus.m_read || bus.m_write) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (k_fixed >= 0) ? k_fixed : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          busy = 1'b0;
          rsp_resp = 1'b1;
          obs_q.push_back(pack_cmd(bus.m_write, bus.m_wmask, bus.m_addr, bus.m_wdata));
          if (bus.m_write) begin
            mem[bus.m_addr[3:0]] = merge(mem[bus.m_addr[3:0]], bus.m_wdata, bus.m_wmask);
          end else begin
            rsp_rdata = mem[bus.m_addr[3:0]];
          end
        end else begin
          cnt--;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] got[10];
    string       nm[10];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = '{16'(bus.m_read), 16'(bus.m_write), 16'(bus.m_wmask), bus.m_addr, bus.m_wdata,
            16'(bus.i_resp), 16'(bus.d_resp), bus.i_rdata, bus.d_rdata, 16'(streak_dbg)};
    nm  = '{"m_read", "m_write", "m_wmask", "m_addr", "m_wdata",
            "i_resp", "d_resp", "i_rdata", "d_rdata", "streak"};
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (got[j] !== 16'h0) begin
        errors++;
        $display("FAIL reset_%s: got %h expected 0000", nm[j], got[j]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_iread();
    bit exp_mr;
    k_fixed = 2;
    bus.i_read = 1'b1;
    bus.i_addr = 16'h3000;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) bus.i_read = 1'b0;
      @(negedge clk);
      exp_mr = (c <= 3);
      checks++;
      if (bus.m_read !== exp_mr) begin
        errors++; $display("FAIL iread_m_read c%0d: got %b expected %b", c, bus.m_read, exp_mr);
      end
      if (exp_mr) begin
        checks++;
        if (bus.m_addr !== 16'h3000) begin
          errors++; $display("FAIL iread_m_addr c%0d: got %h expected 3000", c, bus.m_addr);
        end
      end
      checks++;
      if (bus.i_resp !== (c == 4) || bus.d_resp !== 1'b0) begin
        errors++; $display("FAIL iread_resp c%0d: got i=%b d=%b expected i=%b d=0", c, bus.i_resp, bus.d_resp, c == 4);
      end
      if (c == 4) begin
        checks++;
        if (bus.i_rdata !== 16'h1234) begin
          errors++; $display("FAIL iread_rdata: got %h expected 1234", bus.i_rdata);
        end
      end
    end
    last_i = 16'h1234;
    @(posedge clk);
    #1;
  endtask

  task automatic test_d_write();
    logic [15:0] exp_mem;
    k_fixed = 0;
    exp_mem = merge(mem[1], 16'h00AB, 2'b10);
    bus.d_write = 1'b1;
    bus.d_addr  = 16'h4001;
    bus.d_wdata = 16'h00AB;
    bus.d_wmask = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bus.d_write = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({bus.m_write, bus.m_read, bus.m_addr, bus.m_wdata, bus.m_wmask} !== {2'b10, 16'h4001, 16'h00AB, 2'b10}) begin
          errors++; $display("FAIL dwrite_cmd: got w=%b r=%b a=%h wd=%h mk=%b expected w=1 r=0 a=4001 wd=00ab mk=10",
                             bus.m_write, bus.m_read, bus.m_addr, bus.m_wdata, bus.m_wmask);
        end
      end
      checks++;
      if (bus.d_resp !== (c == 2) || bus.i_resp !== 1'b0) begin
        errors++; $display("FAIL dwrite_resp c%0d: got d=%b i=%b expected d=%b i=0", c, bus.d_resp, bus.i_resp, c == 2);
      end
      if (c == 2) begin
        checks++;
        if (bus.d_rdata !== last_d || bus.i_rdata !== last_i) begin
          errors++; $display("FAIL dwrite_rdata_hold: got d=%h i=%h expected d=%h i=%h", bus.d_rdata, bus.i_rdata, last_d, last_i);
        end
      end
    end
    checks++;
    if (mem[1] !== exp_mem) begin
      errors++; $display("FAIL dwrite_mem: got %h expected %h", mem[1], exp_mem);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_i, exp_d;
    k_fixed = 0;
    exp_i = mem[2];
    exp_d = mem[3];
    bus.i_read = 1'b1; bus.i_addr = 16'h3002;
    bus.d_read = 1'b1; bus.d_addr = 16'h4003;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bus.d_read = 1'b0;
      if (c == 6) bus.i_read = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.m_read !== (c == 1 || c == 4)) begin
        errors++; $display("FAIL simul_m_read c%0d: got %b expected %b", c, bus.m_read, c == 1 || c == 4);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (bus.m_addr !== ((c == 1) ? 16'h4003 : 16'h3002)) begin
          errors++; $display("FAIL simul_m_addr c%0d: got %h expected %h", c, bus.m_addr, (c == 1) ? 16'h4003 : 16'h3002);
        end
      end
      checks++;
      if (bus.d_resp !== (c == 2) || bus.i_resp !== (c == 5)) begin
        errors++; $display("FAIL simul_resp c%0d: got d=%b i=%b expected d=%b i=%b", c, bus.d_resp, bus.i_resp, c == 2, c == 5);
      end
      if (c == 2) begin
        checks++;
        if (bus.d_rdata !== exp_d) begin
          errors++; $display("FAIL simul_d_rdata: got %h expected %h", bus.d_rdata, exp_d);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.i_rdata !== exp_i) begin
          errors++; $display("FAIL simul_i_rdata: got %h expected %h", bus.i_rdata, exp_i);
        end
      end
    end
    last_i = exp_i;
    last_d = exp_d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_starvation();
    int n;
    int cyc;
    bit exp_is_i;
    n = 0;
    cyc = 0;
    k_fixed = 0;
    bus.i_read = 1'b1; bus.i_addr = 16'h3004;
    bus.d_read = 1'b1; bus.d_addr = 16'h4005;
    while (n < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.i_resp || bus.d_resp) begin
        exp_is_i = ((n % 5) == 4);
        checks++;
        if (bus.i_resp !== exp_is_i || bus.d_resp !== !exp_is_i) begin
          errors++; $display("FAIL starve_order n%0d: got i=%b d=%b expected i=%b d=%b", n, bus.i_resp, bus.d_resp, exp_is_i, !exp_is_i);
        end
        checks++;
        if (streak_dbg !== (exp_is_i ? 3'd0 : 3'((n % 5) + 1))) begin
          errors++; $display("FAIL starve_streak n%0d: got %0d expected %0d", n, streak_dbg, exp_is_i ? 0 : (n % 5) + 1);
        end
        checks++;
        if ((exp_is_i ? bus.i_rdata : bus.d_rdata) !== (exp_is_i ? mem[4] : mem[5])) begin
          errors++; $display("FAIL starve_rdata n%0d: got %h expected %h", n, exp_is_i ? bus.i_rdata : bus.d_rdata,
                             exp_is_i ? mem[4] : mem[5]);
        end
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL starve_timeout: got %0d responses expected 10 (state %0d)", n, state_dbg);
    end
    last_i = mem[4];
    last_d = mem[5];
  endtask

  task automatic test_rw_both();
    k_fixed = 1;
    bus.d_read = 1'b1; bus.d_write = 1'b1;
    bus.d_addr = 16'h0006; bus.d_wdata = 16'hBEEF; bus.d_wmask = 2'b11;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 4) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      @(negedge clk);
      checks++;
      if (bus.m_write !== (c <= 2) || bus.m_read !== 1'b0) begin
        errors++; $display("FAIL rw_cmd c%0d: got w=%b r=%b expected w=%b r=0", c, bus.m_write, bus.m_read, c <= 2);
      end
      checks++;
      if (bus.d_resp !== (c == 3)) begin
        errors++; $display("FAIL rw_resp c%0d: got %b expected %b", c, bus.d_resp, c == 3);
      end
      if (c == 3) begin
        checks++;
        if (bus.d_rdata !== last_d) begin
          errors++; $display("FAIL rw_rdata_hold: got %h expected %h", bus.d_rdata, last_d);
        end
      end
    end
    checks++;
    if (mem[6] !== 16'hBEEF) begin
      errors++; $display("FAIL rw_mem: got %h expected beef", mem[6]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_serve();
    logic [15:0] old7;
    logic [15:0] exp_i;
    old7 = mem[7];
    k_fixed = 6;
    bus.d_write = 1'b1; bus.d_addr = 16'h0007; bus.d_wdata = 16'h1357; bus.d_wmask = 2'b11;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.m_write !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got m_write=%b expected 1", bus.m_write);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_read, bus.m_write, bus.m_wmask, bus.m_addr, bus.m_wdata, bus.d_resp, bus.i_resp, streak_dbg} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got r=%b w=%b mk=%b a=%h wd=%h d=%b i=%b streak=%0d expected all 0",
                         bus.m_read, bus.m_write, bus.m_wmask, bus.m_addr, bus.m_wdata, bus.d_resp, bus.i_resp, streak_dbg);
    end
    bus.d_write = 1'b0;
    resp_en  = 1'b0;
    man_resp = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0 || bus.m_read !== 1'b0) begin
        errors++; $display("FAIL rstmid_stray c%0d: got i=%b d=%b r=%b expected 0 0 0", c, bus.i_resp, bus.d_resp, bus.m_read);
      end
      @(posedge clk);
      #1;
    end
    man_resp = 1'b0;
    resp_en  = 1'b1;
    k_fixed  = 0;
    checks++;
    if (mem[7] !== old7 || bus.d_rdata !== 16'h0 || bus.i_rdata !== 16'h0) begin
      errors++; $display("FAIL rstmid_state: got mem7=%h d=%h i=%h expected %h 0000 0000", mem[7], bus.d_rdata, bus.i_rdata, old7);
    end
    last_d = 16'h0;
    exp_i  = mem[8];
    bus.i_read = 1'b1; bus.i_addr = 16'h3008;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bus.i_read = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.m_read !== 1'b1 || bus.m_addr !== 16'h3008) begin
          errors++; $display("FAIL rstmid_fresh_cmd: got r=%b a=%h expected 1 3008", bus.m_read, bus.m_addr);
        end
      end
      checks++;
      if (bus.i_resp !== (c == 2)) begin
        errors++; $display("FAIL rstmid_fresh_resp c%0d: got %b expected %b", c, bus.i_resp, c == 2);
      end
      if (c == 2) begin
        checks++;
        if (bus.i_rdata !== exp_i) begin
          errors++; $display("FAIL rstmid_fresh_rdata: got %h expected %h", bus.i_rdata, exp_i);
        end
      end
    end
    last_i = exp_i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] i_l[$];
    d_item_t     d_l[$];
    d_item_t     it;
    logic [15:0] sh[16];
    logic [15:0] v;
    logic [15:0] exp_v;
    int ni, nd, mi, md, streak, sel;
    int ii, di, got_i, got_d, cyc, nobs;
    bit adv_i, adv_d;
    k_fixed = -1;
    ni = $urandom_range(6, 14);
    nd = $urandom_range(6, 14);
    for (int j = 0; j < ni; j++) i_l.push_back(16'($urandom));
    for (int j = 0; j < nd; j++) begin
      sel   = $urandom_range(0, 2);
      it.rd = (sel != 1);
      it.wr = (sel != 0);
      it.mk = 2'($urandom);
      it.a  = 16'($urandom);
      it.wd = 16'($urandom);
      d_l.push_back(it);
    end
    // Transaction-level reference: both ports keep requesting until their
    // lists are empty, so the grant order follows the priority/starvation rule.
    for (int j = 0; j < 16; j++) sh[j] = mem[j];
    exp_q.delete(); exp_i_q.delete(); exp_d_q.delete(); obs_q.delete();
    mi = 0; md = 0; streak = 0;
    while (mi < ni || md < nd) begin
      if (md < nd && (mi >= ni || streak < LIMIT)) begin
        it = d_l[md];
        md++;
        streak = (mi < ni) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        if (it.wr) begin
          exp_q.push_back(pack_cmd(1'b1, it.mk, it.a, it.wd));
          sh[it.a[3:0]] = merge(sh[it.a[3:0]], it.wd, it.mk);
        end else begin
          exp_q.push_back(pack_cmd(1'b0, 2'b00, it.a, 16'h0));
          last_d = sh[it.a[3:0]];
        end
        exp_d_q.push_back(last_d);
      end else begin
        v = i_l[mi];
        mi++;
        streak = 0;
        exp_q.push_back(pack_cmd(1'b0, 2'b00, v, 16'h0));
        last_i = sh[v[3:0]];
        exp_i_q.push_back(last_i);
      end
    end
    // Drive both ports, presenting the next request in the cycle after a response.
    ii = 0; di = 0; got_i = 0; got_d = 0; cyc = 0;
    bus.i_read = 1'b1; bus.i_addr = i_l[0];
    bus.d_read = d_l[0].rd; bus.d_write = d_l[0].wr;
    bus.d_wmask = d_l[0].mk; bus.d_addr = d_l[0].a; bus.d_wdata = d_l[0].wd;
    while ((got_i < ni || got_d < nd) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      adv_i = 1'b0;
      adv_d = 1'b0;
      if (bus.i_resp) begin
        exp_v = (exp_i_q.size() > 0) ? exp_i_q.pop_front() : 16'hxxxx;
        checks++;
        if (bus.i_rdata !== exp_v) begin
          errors++; $display("FAIL rand_i_rdata #%0d: got %h expected %h", got_i, bus.i_rdata, exp_v);
        end
        got_i++;
        adv_i = 1'b1;
      end
      if (bus.d_resp) begin
        exp_v = (exp_d_q.size() > 0) ? exp_d_q.pop_front() : 16'hxxxx;
        checks++;
        if (bus.d_rdata !== exp_v) begin
          errors++; $display("FAIL rand_d_rdata #%0d: got %h expected %h", got_d, bus.d_rdata, exp_v);
        end
        got_d++;
        adv_d = 1'b1;
      end
      @(posedge clk);
      #1;
      if (adv_i) begin
        ii++;
        if (ii < ni) bus.i_addr = i_l[ii];
        else bus.i_read = 1'b0;
      end
      if (adv_d) begin
        di++;
        if (di < nd) begin
          bus.d_read = d_l[di].rd; bus.d_write = d_l[di].wr;
          bus.d_wmask = d_l[di].mk; bus.d_addr = d_l[di].a; bus.d_wdata = d_l[di].wd;
        end else begin
          bus.d_read = 1'b0; bus.d_write = 1'b0;
        end
      end
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    checks++;
    if (got_i != ni || got_d != nd) begin
      errors++; $display("FAIL rand_timeout: got i=%0d d=%0d expected i=%0d d=%0d (state %0d)", got_i, got_d, ni, nd, state_dbg);
    end
    nobs = obs_q.size();
    checks++;
    if (nobs != exp_q.size()) begin
      errors++; $display("FAIL rand_cmd_count: got %0d expected %0d", nobs, exp_q.size());
    end
    for (int j = 0; j < nobs && j < exp_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        errors++; $display("FAIL rand_cmd #%0d: got %h expected %h", j, obs_q[j], exp_q[j]);
      end
    end
  endtask

  initial begin
    bus.i_read  = 1'b0;
    bus.i_addr  = '0;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    bus.d_wmask = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    last_i = 16'h0;
    last_d = 16'h0;
    test_reset();
    test_single_iread();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_rw_both();
    test_reset_mid_serve();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
